// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache between the IF stage and MemCtrl.
// Hits answer combinationally; a miss issues one MemCtrl word read and fills the line.
module inst_cache #(
  parameter int INDEX_WIDTH = 8,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  IF_inst_read_valid,
  input  logic [ADDR_WIDTH-1:0] IF_inst_addr,
  output logic                  IF_inst_valid,
  output logic [31:0]           IF_inst,
  output logic                  MemCtrl_inst_read_valid,
  output logic [ADDR_WIDTH-1:0] MemCtrl_inst_addr,
  input  logic                  MemCtrl_inst_valid,
  input  logic [31:0]           MemCtrl_inst
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - 2;

  typedef enum logic {IDLE, MISS} state_t;

  state_t state, next_state;

  logic [31:0]      data_mem [LINES];
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [LINES-1:0] valid_bits;

  logic [INDEX_WIDTH-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0]       req_tag, fill_tag;
  logic                   hit, start_miss, do_fill;

  assign req_idx  = IF_inst_addr[INDEX_WIDTH+1:2];
  assign req_tag  = IF_inst_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign fill_idx = MemCtrl_inst_addr[INDEX_WIDTH+1:2];
  assign fill_tag = MemCtrl_inst_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign hit      = valid_bits[req_idx] && (tag_mem[req_idx] == req_tag);

  // Nothing is delivered or advanced while in reset or stalled by rdy.
  always_comb begin
    next_state    = state;
    start_miss    = 1'b0;
    do_fill       = 1'b0;
    IF_inst_valid = 1'b0;
    IF_inst       = '0;
    if (!rst && rdy) begin
      case (state)
        IDLE: begin
          if (IF_inst_read_valid && hit) begin
            IF_inst_valid = 1'b1;
            IF_inst       = data_mem[req_idx];
          end else if (IF_inst_read_valid) begin
            start_miss = 1'b1;
            next_state = MISS;
          end
        end
        MISS: begin
          if (MemCtrl_inst_valid) begin
            do_fill    = 1'b1;
            next_state = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                   <= IDLE;
      valid_bits              <= '0;
      MemCtrl_inst_read_valid <= 1'b0;
      MemCtrl_inst_addr       <= '0;
    end else begin
      state <= next_state;
      if (start_miss) begin
        MemCtrl_inst_read_valid <= 1'b1;
        MemCtrl_inst_addr       <= IF_inst_addr & ~ADDR_WIDTH'(3);
      end
      if (do_fill) begin
        MemCtrl_inst_read_valid <= 1'b0;
        valid_bits[fill_idx]    <= 1'b1;
      end
    end
  end

  // Fills target the latched miss address, even if IF has since redirected.
  always_ff @(posedge clk) begin
    if (do_fill) begin
      data_mem[fill_idx] <= MemCtrl_inst;
      tag_mem[fill_idx]  <= fill_tag;
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: per-cycle vector table plus an async-reset-mid-miss sequence.
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        IF_inst_read_valid;
  logic [31:0] IF_inst_addr;
  logic        IF_inst_valid;
  logic [31:0] IF_inst;
  logic        MemCtrl_inst_read_valid;
  logic [31:0] MemCtrl_inst_addr;
  logic        MemCtrl_inst_valid;
  logic [31:0] MemCtrl_inst;

  int vectors_applied = 0;
  int miscompares     = 0;

  inst_cache #(.INDEX_WIDTH(8), .ADDR_WIDTH(32)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .rdy                    (rdy),
    .IF_inst_read_valid     (IF_inst_read_valid),
    .IF_inst_addr           (IF_inst_addr),
    .IF_inst_valid          (IF_inst_valid),
    .IF_inst                (IF_inst),
    .MemCtrl_inst_read_valid(MemCtrl_inst_read_valid),
    .MemCtrl_inst_addr      (MemCtrl_inst_addr),
    .MemCtrl_inst_valid     (MemCtrl_inst_valid),
    .MemCtrl_inst           (MemCtrl_inst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] addr;
    logic        mv;
    logic [31:0] minst;
    logic        exp_iv;
    logic [31:0] exp_inst;
    logic        exp_mrv;
    logic [31:0] exp_maddr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic rv, input logic [31:0] a,
                              input logic mv, input logic [31:0] mi, input logic iv,
                              input logic [31:0] ins, input logic mrv, input logic [31:0] ma);
    vec_t v;
    v = '{r, rv, a, mv, mi, iv, ins, mrv, ma};
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input logic r, input logic rv, input logic [31:0] a,
                               input logic mv, input logic [31:0] mi);
    rdy                = r;
    IF_inst_read_valid = rv;
    IF_inst_addr       = a;
    MemCtrl_inst_valid = mv;
    MemCtrl_inst       = mi;
  endtask

  task automatic checkOutput(input string name, input logic iv, input logic [31:0] ins,
                             input logic mrv, input logic [31:0] ma);
    vectors_applied++;
    if (IF_inst_valid !== iv) begin
      miscompares++;
      $display("[TB] FAIL %s IF_inst_valid: got %b expected %b", name, IF_inst_valid, iv);
    end
    if (IF_inst !== ins) begin
      miscompares++;
      $display("[TB] FAIL %s IF_inst: got %h expected %h", name, IF_inst, ins);
    end
    if (MemCtrl_inst_read_valid !== mrv) begin
      miscompares++;
      $display("[TB] FAIL %s MemCtrl_inst_read_valid: got %b expected %b", name,
               MemCtrl_inst_read_valid, mrv);
    end
    if (MemCtrl_inst_addr !== ma) begin
      miscompares++;
      $display("[TB] FAIL %s MemCtrl_inst_addr: got %h expected %h", name, MemCtrl_inst_addr, ma);
    end
  endtask

  initial begin
    // Cold miss on 0x0, MemCtrl answers on the 4th cycle after the request
    add(1,1,32'h0,  0,32'h0,        0,32'h0,        0,32'h0);
    add(1,1,32'h0,  0,32'h0,        0,32'h0,        1,32'h0);
    add(1,1,32'h0,  0,32'h0,        0,32'h0,        1,32'h0);
    add(1,1,32'h0,  0,32'h0,        0,32'h0,        1,32'h0);
    add(1,1,32'h0,  1,32'h00500093, 0,32'h0,        1,32'h0);
    add(1,1,32'h0,  0,32'h0,        1,32'h00500093, 0,32'h0);
    // Preload 0x4 and 0x8
    add(1,1,32'h4,  0,32'h0,        0,32'h0,        0,32'h0);
    add(1,1,32'h4,  1,32'h00100113, 0,32'h0,        1,32'h4);
    add(1,1,32'h8,  0,32'h0,        0,32'h0,        0,32'h4);
    add(1,1,32'h8,  1,32'h00200193, 0,32'h0,        1,32'h8);
    // Back-to-back hits, then an idle cycle
    add(1,1,32'h0,  0,32'h0,        1,32'h00500093, 0,32'h8);
    add(1,1,32'h4,  0,32'h0,        1,32'h00100113, 0,32'h8);
    add(1,1,32'h8,  0,32'h0,        1,32'h00200193, 0,32'h8);
    add(1,0,32'h0,  0,32'h0,        0,32'h0,        0,32'h8);
    // Stray MemCtrl pulse while IDLE must not write anything
    add(1,0,32'hC,  1,32'hDEADBEEF, 0,32'h0,        0,32'h8);
    add(1,1,32'hC,  0,32'h0,        0,32'h0,        0,32'h8);
    add(1,1,32'hC,  1,32'h00300213, 0,32'h0,        1,32'hC);
    add(1,1,32'hC,  0,32'h0,        1,32'h00300213, 0,32'hC);
    add(1,1,32'h8,  0,32'h0,        1,32'h00200193, 0,32'hC);
    // Same-index conflict 0x10 / 0x410
    add(1,1,32'h10, 0,32'h0,        0,32'h0,        0,32'hC);
    add(1,1,32'h10, 1,32'h11111111, 0,32'h0,        1,32'h10);
    add(1,1,32'h10, 0,32'h0,        1,32'h11111111, 0,32'h10);
    add(1,1,32'h410,0,32'h0,        0,32'h0,        0,32'h10);
    add(1,1,32'h410,1,32'h22222222, 0,32'h0,        1,32'h410);
    add(1,1,32'h410,0,32'h0,        1,32'h22222222, 0,32'h410);
    add(1,1,32'h10, 0,32'h0,        0,32'h0,        0,32'h410);
    add(1,1,32'h10, 1,32'h11111111, 0,32'h0,        1,32'h10);
    add(1,1,32'h10, 0,32'h0,        1,32'h11111111, 0,32'h10);
    // Redirect during a miss; a hitting address is still blocked in MISS
    add(1,1,32'h20, 0,32'h0,        0,32'h0,        0,32'h10);
    add(1,1,32'h20, 0,32'h0,        0,32'h0,        1,32'h20);
    add(1,1,32'h0,  0,32'h0,        0,32'h0,        1,32'h20);
    add(1,1,32'h100,1,32'h33333333, 0,32'h0,        1,32'h20);
    add(1,1,32'h100,0,32'h0,        0,32'h0,        0,32'h20);
    add(1,1,32'h100,1,32'h44444444, 0,32'h0,        1,32'h100);
    add(1,1,32'h100,0,32'h0,        1,32'h44444444, 0,32'h100);
    add(1,1,32'h20, 0,32'h0,        1,32'h33333333, 0,32'h100);
    // rdy low mid-MISS: pulse during the stall is ignored, request stays up
    add(1,1,32'h30, 0,32'h0,        0,32'h0,        0,32'h100);
    add(0,1,32'h30, 0,32'h0,        0,32'h0,        1,32'h30);
    add(0,1,32'h30, 1,32'h55555555, 0,32'h0,        1,32'h30);
    add(0,1,32'h0,  0,32'h0,        0,32'h0,        1,32'h30);
    add(1,1,32'h30, 1,32'h66666666, 0,32'h0,        1,32'h30);
    add(1,1,32'h30, 0,32'h0,        1,32'h66666666, 0,32'h30);
    // rdy low in IDLE: no delivery on a hit, no miss started
    add(0,1,32'h30, 0,32'h0,        0,32'h0,        0,32'h30);
    add(0,1,32'h34, 0,32'h0,        0,32'h0,        0,32'h30);
    add(0,1,32'h34, 0,32'h0,        0,32'h0,        0,32'h30);
    add(1,1,32'h34, 0,32'h0,        0,32'h0,        0,32'h30);
    add(1,1,32'h34, 1,32'h77777777, 0,32'h0,        1,32'h34);
    add(1,1,32'h34, 0,32'h0,        1,32'h77777777, 0,32'h34);

    applyStimulus(1, 0, 32'h0, 0, 32'h0);
    rst = 1'b1;
    #3;
    checkOutput("reset", 0, 32'h0, 0, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rdy, vecs[i].rv, vecs[i].addr, vecs[i].mv, vecs[i].minst);
      #1;
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_iv, vecs[i].exp_inst,
                  vecs[i].exp_mrv, vecs[i].exp_maddr);
      @(negedge clk);
    end

    // Async reset pulse between edges while a miss on 0x40 is pending
    applyStimulus(1, 1, 32'h40, 0, 32'h0);
    #1;
    checkOutput("rst_pre", 0, 32'h0, 0, 32'h34);
    @(negedge clk);
    #1;
    checkOutput("rst_miss", 0, 32'h0, 1, 32'h40);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_drop", 0, 32'h0, 0, 32'h0);
    #1;
    rst = 1'b0;
    applyStimulus(1, 1, 32'h0, 1, 32'h88888888);
    @(negedge clk);
    applyStimulus(1, 1, 32'h0, 0, 32'h0);
    #1;
    checkOutput("rst_0_miss", 0, 32'h0, 1, 32'h0);
    @(negedge clk);
    applyStimulus(1, 1, 32'h0, 1, 32'h00500093);
    #1;
    checkOutput("rst_fill", 0, 32'h0, 1, 32'h0);
    @(negedge clk);
    applyStimulus(1, 1, 32'h0, 0, 32'h0);
    #1;
    checkOutput("rst_refill_hit", 1, 32'h00500093, 0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
- Direct-mapped, one-word-per-line instruction cache between the IF stage (upstream requester) and the memory controller (MemCtrl).
- Hits are answered combinationally in the same cycle.
- Misses run a single outstanding MemCtrl word read, fill the line, and the retried request then hits.
- Read-only. No write path, no invalidation except reset.

Parameters:
INDEX_WIDTH, 8, line index bits; 2^INDEX_WIDTH lines of one 32-bit instruction each
ADDR_WIDTH, 32, byte address width; tag = addr[ADDR_WIDTH-1:INDEX_WIDTH+2]

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
rdy  input  1  global enable; when low, state frozen and no delivery
IF_inst_read_valid  input  1  IF requests instruction at IF_inst_addr
IF_inst_addr  input  32  requested byte address; bits[1:0] ignored
IF_inst_valid  output  1  IF_inst carries the instruction for the current IF_inst_addr
IF_inst  output  32  instruction word
MemCtrl_inst_read_valid  output  1  miss fetch request, held until served
MemCtrl_inst_addr  output  32  word-aligned miss address
MemCtrl_inst_valid  input  1  one-cycle pulse: MemCtrl_inst is the requested word
MemCtrl_inst  input  32  fetched word

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous and active-high.
- Storage: data[2^INDEX_WIDTH] x32, tag[2^INDEX_WIDTH], valid[2^INDEX_WIDTH]. Index = addr[INDEX_WIDTH+1:2].
- hit = valid[idx] && tag[idx] == addr tag.
- Reset (async, immediate):
  - all valid bits = 0
  - state = IDLE
  - MemCtrl_inst_read_valid = 0, MemCtrl_inst_addr = 0
  - IF_inst_valid = 0 and IF_inst = 0 while rst high
  - data/tag arrays need no reset
- IF_inst_valid = !rst && rdy && state==IDLE && IF_inst_read_valid && hit. Combinational, 0-cycle latency.
- IF_inst = data[idx] when IF_inst_valid, else 0.
- IF changes the address only at a clock edge, so each valid cycle corresponds to exactly one address. No duplicate suppression is needed.
- FSM (advances only when rdy=1):
  - IDLE:
    - If IF_inst_read_valid && !hit: MemCtrl_inst_addr <= {IF_inst_addr[31:2],2'b00}, MemCtrl_inst_read_valid <= 1, go to MISS.
    - Otherwise stay in IDLE.
  - MISS:
    - IF_inst_valid forced 0, including for addresses that would hit.
    - MemCtrl_inst_read_valid and MemCtrl_inst_addr held stable.
    - On MemCtrl_inst_valid=1: data/tag/valid[idx of MemCtrl_inst_addr] <= MemCtrl_inst / tag / 1; MemCtrl_inst_read_valid <= 0; go to IDLE.
- Miss latency: request cycle + MemCtrl latency + 1 cycle. The first hit is the cycle after the fill edge.
- IF address changes during MISS (jump/redirect): the fill completes for the latched address and is written normally. Back in IDLE the current address is re-evaluated, possibly starting a new miss. There is no abort path, because MemCtrl cannot cancel.
- MemCtrl_inst_valid while IDLE: ignored, no write.
- Same-index conflict: a fill overwrites the resident line unconditionally.
- rdy=0: no state, array or output register changes; pending MemCtrl request stays asserted; IF_inst_valid = 0.
- Reset mid-MISS: request dropped immediately; a MemCtrl_inst_valid arriving after reset release is ignored (state IDLE).

Test Plan:
- Cold miss: reset, request 0x00000000, MemCtrl returns 0x00500093 after 4 cycles -> MemCtrl_inst_read_valid high with addr 0x0 from cycle 1 until the fill edge; IF_inst_valid=1, IF_inst=0x00500093 the cycle after the fill.
- Sequential hits: preload 0x0/0x4/0x8, then step addresses each cycle -> IF_inst_valid=1 on the same cycle for each, no MemCtrl activity.
- Conflict: fill 0x00000010, then request 0x00000410 (same index, INDEX_WIDTH=8) -> miss and fill. A subsequent request to 0x10 misses again.
- Redirect during miss: miss on 0x20, switch IF_inst_addr to 0x100 two cycles later -> fill for 0x20 still written; then a new miss on 0x100; a later request to 0x20 hits.
- rdy low: assert rdy=0 mid-MISS for 3 cycles with a MemCtrl pulse arriving in that window held off by the bench -> no state change and IF_inst_valid=0; resumes correctly after rdy=1.
- Async reset mid-MISS: pulse rst between clock edges -> MemCtrl_inst_read_valid drops immediately; previously cached 0x0 now misses.
